// File: rtl/line_follow_controller.sv
`default_nettype none
// ============================================================================
// Module   : line_follow_controller
// Brief    : Turns the filtered tracker decision code into per-wheel speed,
//            direction and PWM, with ramping and lost-line recovery/halt.
// Revision : 1.0 - initial release
// ============================================================================
module line_follow_controller #(
  parameter int W         = 10,
  parameter int SPD_FAST  = 800,
  parameter int SPD_SLOW  = 400,
  parameter int SPD_SHARP = 300,
  parameter int STABLE_N  = 4,
  parameter int RAMP_DIV  = 16,
  parameter int RAMP_STEP = 32,
  parameter int LOST_N    = 2000,
  parameter int RECOVER_N = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [2:0]   track_code,
  input  logic         line_lost,
  output logic [W-1:0] speed_l,
  output logic [W-1:0] speed_r,
  output logic         dir_l,
  output logic         dir_r,
  output logic         pwm_l,
  output logic         pwm_r,
  output logic [1:0]   fsm_state
);

  localparam int c_stab_w = $clog2(STABLE_N + 1);
  localparam int c_div_w  = $clog2(RAMP_DIV + 1);
  localparam int c_lost_w = $clog2(LOST_N + 1);
  localparam int c_rec_w  = $clog2(RECOVER_N + 1);

  localparam logic [c_stab_w-1:0] c_stable_n  = c_stab_w'(STABLE_N);
  localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(RAMP_DIV - 1);
  localparam logic [c_div_w-1:0]  c_div_one   = c_div_w'(1);
  localparam logic [c_lost_w-1:0] c_lost_n    = c_lost_w'(LOST_N);
  localparam logic [c_lost_w-1:0] c_lost_one  = c_lost_w'(1);
  localparam logic [c_rec_w-1:0]  c_recover_n = c_rec_w'(RECOVER_N);
  localparam logic [c_rec_w-1:0]  c_rec_one   = c_rec_w'(1);

  localparam logic [W-1:0] c_fast  = W'(SPD_FAST);
  localparam logic [W-1:0] c_slow  = W'(SPD_SLOW);
  localparam logic [W-1:0] c_sharp = W'(SPD_SHARP);
  localparam logic [W-1:0] c_step  = W'(RAMP_STEP);
  localparam logic [W-1:0] c_one   = W'(1);

  localparam logic [2:0] c_code_l        = 3'b000;
  localparam logic [2:0] c_code_r        = 3'b001;
  localparam logic [2:0] c_code_straight = 3'b010;
  localparam logic [2:0] c_code_stop     = 3'b011;
  localparam logic [2:0] c_code_sharp_l  = 3'b100;
  localparam logic [2:0] c_code_sharp_r  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_RECOVER = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  state_t              state_q,     state_d;
  logic [2:0]          cand_q,      cand_d;
  logic [c_stab_w-1:0] stab_cnt_q,  stab_cnt_d;
  logic [2:0]          acc_q,       acc_d;
  logic                last_right_q, last_right_d;
  logic [c_div_w-1:0]  div_cnt_q,   div_cnt_d;
  logic [c_lost_w-1:0] lost_cnt_q,  lost_cnt_d;
  logic [c_stab_w-1:0] found_cnt_q, found_cnt_d;
  logic [c_rec_w-1:0]  rec_cnt_q,   rec_cnt_d;
  logic [W-1:0]        spd_l_q,     spd_l_d;
  logic [W-1:0]        spd_r_q,     spd_r_d;
  logic                dir_l_q,     dir_l_d;
  logic                dir_r_q,     dir_r_d;
  logic [W-1:0]        pwm_cnt_q,   pwm_cnt_d;
  logic                pwm_l_q,     pwm_l_d;
  logic                pwm_r_q,     pwm_r_d;

  logic                w_tick;
  logic                w_tgt_dir_l;
  logic                w_tgt_dir_r;
  logic [W-1:0]        w_tgt_mag_l;
  logic [W-1:0]        w_tgt_mag_r;

  // One ramp tick for one wheel; returns {dir, speed}. A wheel facing the
  // wrong way is brought to rest first and only then turned around.
  function automatic logic [W:0] f_ramp(
    input logic         cur_dir,
    input logic [W-1:0] cur_spd,
    input logic         tgt_dir,
    input logic [W-1:0] tgt_mag
  );
    logic [W-1:0] diff;
    logic [W-1:0] amt;
    logic         nxt_dir;
    logic [W-1:0] nxt_spd;
    nxt_dir = cur_dir;
    nxt_spd = cur_spd;
    if (tgt_dir != cur_dir) begin
      diff = cur_spd;
    end else if (cur_spd > tgt_mag) begin
      diff = cur_spd - tgt_mag;
    end else begin
      diff = tgt_mag - cur_spd;
    end
    amt = (diff > c_step) ? c_step : diff;
    if (tgt_dir != cur_dir) begin
      if (cur_spd == '0) begin
        nxt_dir = tgt_dir;
      end else begin
        nxt_spd = cur_spd - amt;
      end
    end else if (cur_spd > tgt_mag) begin
      nxt_spd = cur_spd - amt;
    end else begin
      nxt_spd = cur_spd + amt;
    end
    return {nxt_dir, nxt_spd};
  endfunction

  // Stability filter: undefined codes may become the candidate but never win.
  always_comb begin
    cand_d       = cand_q;
    stab_cnt_d   = stab_cnt_q;
    acc_d        = acc_q;
    last_right_d = last_right_q;
    if (track_code != cand_q) begin
      cand_d     = track_code;
      stab_cnt_d = c_stab_one;
    end else if (stab_cnt_q != c_stable_n) begin
      stab_cnt_d = stab_cnt_q + c_stab_one;
    end
    if ((stab_cnt_d == c_stable_n) && (cand_d <= c_code_sharp_r)) begin
      acc_d = cand_d;
      case (cand_d)
        c_code_l, c_code_sharp_l: last_right_d = 1'b0;
        c_code_r, c_code_sharp_r: last_right_d = 1'b1;
        default:                  last_right_d = last_right_q;
      endcase
    end
  end

  always_comb begin
    w_tgt_dir_l = dir_l_q;
    w_tgt_dir_r = dir_r_q;
    w_tgt_mag_l = '0;
    w_tgt_mag_r = '0;
    case (state_q)
      ST_RUN: begin
        case (acc_q)
          c_code_straight: begin
            w_tgt_dir_l = 1'b1; w_tgt_mag_l = c_fast;
            w_tgt_dir_r = 1'b1; w_tgt_mag_r = c_fast;
          end
          c_code_l: begin
            w_tgt_dir_l = 1'b1; w_tgt_mag_l = c_slow;
            w_tgt_dir_r = 1'b1; w_tgt_mag_r = c_fast;
          end
          c_code_r: begin
            w_tgt_dir_l = 1'b1; w_tgt_mag_l = c_fast;
            w_tgt_dir_r = 1'b1; w_tgt_mag_r = c_slow;
          end
          c_code_sharp_l: begin
            w_tgt_dir_l = 1'b0; w_tgt_mag_l = c_sharp;
            w_tgt_dir_r = 1'b1; w_tgt_mag_r = c_fast;
          end
          c_code_sharp_r: begin
            w_tgt_dir_l = 1'b1; w_tgt_mag_l = c_fast;
            w_tgt_dir_r = 1'b0; w_tgt_mag_r = c_sharp;
          end
          default: begin
            w_tgt_mag_l = '0;
            w_tgt_mag_r = '0;
          end
        endcase
      end
      ST_RECOVER: begin
        // Spin toward the side the line was last seen on.
        if (last_right_q) begin
          w_tgt_dir_l = 1'b1; w_tgt_mag_l = c_fast;
          w_tgt_dir_r = 1'b0; w_tgt_mag_r = c_sharp;
        end else begin
          w_tgt_dir_l = 1'b0; w_tgt_mag_l = c_sharp;
          w_tgt_dir_r = 1'b1; w_tgt_mag_r = c_fast;
        end
      end
      default: begin
        w_tgt_mag_l = '0;
        w_tgt_mag_r = '0;
      end
    endcase
  end

  always_comb begin
    w_tick    = (div_cnt_q == c_div_last);
    div_cnt_d = w_tick ? '0 : (div_cnt_q + c_div_one);
    {dir_l_d, spd_l_d} = {dir_l_q, spd_l_q};
    {dir_r_d, spd_r_d} = {dir_r_q, spd_r_q};
    if (w_tick) begin
      {dir_l_d, spd_l_d} = f_ramp(dir_l_q, spd_l_q, w_tgt_dir_l, w_tgt_mag_l);
      {dir_r_d, spd_r_d} = f_ramp(dir_r_q, spd_r_q, w_tgt_dir_r, w_tgt_mag_r);
    end
  end

  always_comb begin
    state_d     = state_q;
    lost_cnt_d  = '0;
    found_cnt_d = '0;
    rec_cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (line_lost) begin
          lost_cnt_d = (lost_cnt_q == c_lost_n) ? lost_cnt_q : (lost_cnt_q + c_lost_one);
        end
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (lost_cnt_d == c_lost_n) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        rec_cnt_d = (rec_cnt_q == c_recover_n) ? rec_cnt_q : (rec_cnt_q + c_rec_one);
        if (!line_lost) begin
          found_cnt_d = (found_cnt_q == c_stable_n) ? found_cnt_q : (found_cnt_q + c_stab_one);
        end
        // Finding the line again wins over a timeout landing on the same cycle.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (found_cnt_d == c_stable_n) begin
          state_d = ST_RUN;
        end else if (rec_cnt_d == c_recover_n) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + c_one;
    pwm_l_d   = (pwm_cnt_q < spd_l_q);
    pwm_r_d   = (pwm_cnt_q < spd_r_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_q       <= c_code_stop;
      stab_cnt_q   <= '0;
      acc_q        <= c_code_stop;
      last_right_q <= 1'b0;
      div_cnt_q    <= '0;
      lost_cnt_q   <= '0;
      found_cnt_q  <= '0;
      rec_cnt_q    <= '0;
      spd_l_q      <= '0;
      spd_r_q      <= '0;
      dir_l_q      <= 1'b1;
      dir_r_q      <= 1'b1;
      pwm_cnt_q    <= '0;
      pwm_l_q      <= 1'b0;
      pwm_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stab_cnt_q   <= stab_cnt_d;
      acc_q        <= acc_d;
      last_right_q <= last_right_d;
      div_cnt_q    <= div_cnt_d;
      lost_cnt_q   <= lost_cnt_d;
      found_cnt_q  <= found_cnt_d;
      rec_cnt_q    <= rec_cnt_d;
      spd_l_q      <= spd_l_d;
      spd_r_q      <= spd_r_d;
      dir_l_q      <= dir_l_d;
      dir_r_q      <= dir_r_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pwm_l_q      <= pwm_l_d;
      pwm_r_q      <= pwm_r_d;
    end
  end

  assign speed_l   = spd_l_q;
  assign speed_r   = spd_r_q;
  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;
  assign fsm_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_line_follow_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_follow_controller
// Brief    : Vector table, directed corner sequences and random stimulus
//            against a behavioural model of line_follow_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_follow_controller;

  localparam int W         = 10;
  localparam int SPD_FAST  = 800;
  localparam int SPD_SLOW  = 400;
  localparam int SPD_SHARP = 300;
  localparam int STABLE_N  = 4;
  localparam int RAMP_DIV  = 16;
  localparam int RAMP_STEP = 32;
  localparam int LOST_N    = 200;
  localparam int RECOVER_N = 600;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [2:0]   track_code;
  logic         line_lost;
  logic [W-1:0] speed_l;
  logic [W-1:0] speed_r;
  logic         dir_l;
  logic         dir_r;
  logic         pwm_l;
  logic         pwm_r;
  logic [1:0]   fsm_state;

  line_follow_controller #(
    .W(W), .SPD_FAST(SPD_FAST), .SPD_SLOW(SPD_SLOW), .SPD_SHARP(SPD_SHARP),
    .STABLE_N(STABLE_N), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP),
    .LOST_N(LOST_N), .RECOVER_N(RECOVER_N)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .track_code(track_code),
    .line_lost(line_lost), .speed_l(speed_l), .speed_r(speed_r),
    .dir_l(dir_l), .dir_r(dir_r), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: 0 IDLE, 1 RUN, 2 RECOVER, 3 HALT; index 0 = left, 1 = right.
  int m_state, m_acc, m_cand, m_run, m_last, m_lost, m_found, m_rec, m_n, m_cnt;
  int m_dir[2];
  int m_spd[2];
  int m_pwm[2];

  task automatic model_reset();
    m_state = 0; m_acc = 3; m_cand = 3; m_run = 0; m_last = 0;
    m_lost = 0; m_found = 0; m_rec = 0; m_n = 0; m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_dir[i] = 1; m_spd[i] = 0; m_pwm[i] = 0;
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int code, input bit lost);
    int eff, st0;
    int td[2];
    int tm[2];
    int delta;
    if (rst) begin
      model_reset();
      return;
    end
    td[0] = m_dir[0]; td[1] = m_dir[1]; tm[0] = 0; tm[1] = 0;
    eff = (m_state == 1) ? m_acc : (m_state == 2) ? (m_last ? 5 : 4) : 3;
    case (eff)
      2: begin td[0] = 1; tm[0] = SPD_FAST;  td[1] = 1; tm[1] = SPD_FAST;  end
      0: begin td[0] = 1; tm[0] = SPD_SLOW;  td[1] = 1; tm[1] = SPD_FAST;  end
      1: begin td[0] = 1; tm[0] = SPD_FAST;  td[1] = 1; tm[1] = SPD_SLOW;  end
      4: begin td[0] = 0; tm[0] = SPD_SHARP; td[1] = 1; tm[1] = SPD_FAST;  end
      5: begin td[0] = 1; tm[0] = SPD_FAST;  td[1] = 0; tm[1] = SPD_SHARP; end
      default: ;
    endcase
    for (int i = 0; i < 2; i++) m_pwm[i] = (m_cnt < m_spd[i]) ? 1 : 0;
    m_cnt = (m_cnt + 1) % (1 << W);
    if ((m_n % RAMP_DIV) == RAMP_DIV - 1) begin
      for (int i = 0; i < 2; i++) begin
        if (td[i] == m_dir[i]) begin
          delta = tm[i] - m_spd[i];
          if (delta > RAMP_STEP)  delta = RAMP_STEP;
          if (delta < -RAMP_STEP) delta = -RAMP_STEP;
          m_spd[i] = m_spd[i] + delta;
        end else if (m_spd[i] > 0) begin
          m_spd[i] = m_spd[i] - ((m_spd[i] < RAMP_STEP) ? m_spd[i] : RAMP_STEP);
        end else begin
          m_dir[i] = td[i];
        end
      end
    end
    m_n++;
    st0 = m_state;
    case (st0)
      0: if (en) m_state = 1;
      1: begin
        m_lost = lost ? m_lost + 1 : 0;
        if (!en) m_state = 0;
        else if (m_lost >= LOST_N) m_state = 2;
      end
      2: begin
        m_rec++;
        m_found = lost ? 0 : m_found + 1;
        if (!en) m_state = 0;
        else if (m_found >= STABLE_N) m_state = 1;
        else if (m_rec >= RECOVER_N) m_state = 3;
      end
      default: if (!en) m_state = 0;
    endcase
    if (st0 != 1) m_lost = 0;
    if (st0 != 2) begin m_rec = 0; m_found = 0; end
    if (code == m_cand) m_run++;
    else begin m_cand = code; m_run = 1; end
    if (m_run >= STABLE_N && m_cand < 6) begin
      m_acc = m_cand;
      if (m_cand == 0 || m_cand == 4) m_last = 0;
      else if (m_cand == 1 || m_cand == 5) m_last = 1;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [2:0] code, input bit lost);
    reset = rst; enable = en; track_code = code; line_lost = lost;
    @(posedge clk);
    model_step(rst, en, int'(code), lost);
    cyc++;
    #1;
    checks++;
    if (speed_l !== W'(m_spd[0]) || speed_r !== W'(m_spd[1]) ||
        dir_l !== 1'(m_dir[0]) || dir_r !== 1'(m_dir[1]) ||
        pwm_l !== 1'(m_pwm[0]) || pwm_r !== 1'(m_pwm[1]) ||
        fsm_state !== 2'(m_state)) begin
      fails++;
      $display("FAIL model_cmp cyc=%0d got sl=%0d sr=%0d dl=%0b dr=%0b pl=%0b pr=%0b st=%0d required sl=%0d sr=%0d dl=%0d dr=%0d pl=%0d pr=%0d st=%0d",
               cyc, speed_l, speed_r, dir_l, dir_r, pwm_l, pwm_r, fsm_state,
               m_spd[0], m_spd[1], m_dir[0], m_dir[1], m_pwm[0], m_pwm[1], m_state);
    end
  endtask

  typedef struct {
    bit         en;
    logic [2:0] code;
    bit         lost;
    int         hold;
    int         sl;
    int         sr;
    bit         dl;
    bit         dr;
    int         st;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit         ren, rl, rrst;
    logic [2:0] rc;
    int         cseg, lseg;

    // Cycle counts are from the first edge after reset; ramp ticks fall on every 16th edge.
    tbl[0] = '{1'b1, 3'b010, 1'b0,   1,   0,   0, 1'b1, 1'b1, 1};
    tbl[1] = '{1'b1, 3'b010, 1'b0, 398, 768, 768, 1'b1, 1'b1, 1};
    tbl[2] = '{1'b1, 3'b010, 1'b0,   1, 800, 800, 1'b1, 1'b1, 1};
    tbl[3] = '{1'b1, 3'b001, 1'b0,   3, 800, 800, 1'b1, 1'b1, 1};
    tbl[4] = '{1'b1, 3'b010, 1'b0,  30, 800, 800, 1'b1, 1'b1, 1};
    tbl[5] = '{1'b1, 3'b100, 1'b0, 399,   0, 800, 1'b1, 1'b1, 1};
    tbl[6] = '{1'b1, 3'b100, 1'b0,  16,   0, 800, 1'b0, 1'b1, 1};
    tbl[7] = '{1'b1, 3'b100, 1'b0, 144, 288, 800, 1'b0, 1'b1, 1};
    tbl[8] = '{1'b1, 3'b100, 1'b0,  16, 300, 800, 1'b0, 1'b1, 1};

    step(1'b1, 1'b0, 3'b011, 1'b0);
    step(1'b1, 1'b0, 3'b011, 1'b0);
    check("rst_speed_l", int'(speed_l), 0);
    check("rst_speed_r", int'(speed_r), 0);
    check("rst_dirs", int'({dir_l, dir_r}), 3);
    check("rst_pwm", int'({pwm_l, pwm_r}), 0);
    check("rst_state", int'(fsm_state), 0);

    for (int v = 0; v < 9; v++) begin
      repeat (tbl[v].hold) step(1'b0, tbl[v].en, tbl[v].code, tbl[v].lost);
      check($sformatf("tbl%0d_speed_l", v), int'(speed_l), tbl[v].sl);
      check($sformatf("tbl%0d_speed_r", v), int'(speed_r), tbl[v].sr);
      check($sformatf("tbl%0d_dir_l", v), int'(dir_l), int'(tbl[v].dl));
      check($sformatf("tbl%0d_dir_r", v), int'(dir_r), int'(tbl[v].dr));
      check($sformatf("tbl%0d_state", v), int'(fsm_state), tbl[v].st);
    end

    // Undefined code after an accepted left turn leaves the left-turn targets in force.
    repeat (6)  step(1'b0, 1'b1, 3'b000, 1'b0);
    repeat (64) step(1'b0, 1'b1, 3'b111, 1'b0);
    check("inv_speed_l", int'(speed_l), 172);
    check("inv_dir_l", int'(dir_l), 0);
    check("inv_speed_r", int'(speed_r), 800);

    // Lost line after a right turn: recovery spins with the right wheel reversed.
    repeat (10) step(1'b0, 1'b1, 3'b001, 1'b0);
    repeat (LOST_N - 1) step(1'b0, 1'b1, 3'b001, 1'b1);
    check("lost_pre_state", int'(fsm_state), 1);
    step(1'b0, 1'b1, 3'b001, 1'b1);
    check("lost_recover_state", int'(fsm_state), 2);
    repeat (300) step(1'b0, 1'b1, 3'b001, 1'b1);
    check("recover_dir_r", int'(dir_r), 0);
    check("recover_dir_l", int'(dir_l), 1);
    repeat (STABLE_N - 1) step(1'b0, 1'b1, 3'b001, 1'b0);
    check("found_pre_state", int'(fsm_state), 2);
    step(1'b0, 1'b1, 3'b001, 1'b0);
    check("found_run_state", int'(fsm_state), 1);

    // Recovery timeout into HALT, ramp to rest, then disable.
    repeat (LOST_N) step(1'b0, 1'b1, 3'b001, 1'b1);
    check("halt_path_recover", int'(fsm_state), 2);
    repeat (RECOVER_N - 1) step(1'b0, 1'b1, 3'b001, 1'b1);
    check("halt_pre_state", int'(fsm_state), 2);
    step(1'b0, 1'b1, 3'b001, 1'b1);
    check("halt_state", int'(fsm_state), 3);
    repeat (600) step(1'b0, 1'b1, 3'b001, 1'b1);
    check("halt_speeds", int'(speed_l) + int'(speed_r), 0);
    check("halt_hold_state", int'(fsm_state), 3);
    step(1'b0, 1'b0, 3'b001, 1'b0);
    check("halt_to_idle", int'(fsm_state), 0);

    // Disable while running: IDLE at once, wheels only ramp down.
    repeat (500) step(1'b0, 1'b1, 3'b010, 1'b0);
    check("run_full_l", int'(speed_l), 800);
    check("run_full_r", int'(speed_r), 800);
    step(1'b0, 1'b0, 3'b010, 1'b0);
    check("disable_idle", int'(fsm_state), 0);
    check("disable_no_snap", int'(speed_l >= W'(768)), 1);

    // Reset in the middle of a reversal ramp.
    repeat (40) step(1'b0, 1'b1, 3'b100, 1'b0);
    step(1'b1, 1'b1, 3'b100, 1'b0);
    check("midrst_speeds", int'(speed_l) + int'(speed_r), 0);
    check("midrst_dirs", int'({dir_l, dir_r}), 3);
    check("midrst_pwm", int'({pwm_l, pwm_r}), 0);
    check("midrst_state", int'(fsm_state), 0);

    ren = 1'b1; rl = 1'b0; rc = 3'b010; cseg = 0; lseg = 0;
    for (int c = 0; c < 9000; c++) begin
      if (cseg == 0) begin
        rc   = 3'($urandom_range(0, 7));
        cseg = $urandom_range(1, 8);
      end
      if (lseg == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          rl = 1'b1; lseg = $urandom_range(150, 900);
        end else begin
          rl = ($urandom_range(0, 3) == 0); lseg = $urandom_range(1, 30);
        end
      end
      if ($urandom_range(0, 599) == 0) ren = ~ren;
      if (!ren && $urandom_range(0, 49) == 0) ren = 1'b1;
      rrst = ($urandom_range(0, 2999) == 0);
      step(rrst, ren, rc, rl);
      cseg--;
      lseg--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
